// File: rtl/fft_pkg.sv
// Shared FFT datapath constants and sizing helpers.
// Used by the pipeline stages and the elastic buffers between them.
package fft_pkg;

  localparam int FFT_WORD_W = 32;

  // Number of bits needed to hold a value in the range 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/reg_fifo_ctrl.sv
// Control path of the register FIFO. It holds the pointers, the occupancy count
// and the sticky flags, and decides which write and pop requests are accepted.
module reg_fifo_ctrl
  import fft_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic             wr_acc,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;
  logic             rd_acc;

  // DEPTH need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full        = (count_reg == CNT_W'(DEPTH));
  assign empty       = (count_reg == '0);
  assign almost_full = (count_reg >= CNT_W'(AF_THRESH));

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write with rd_en.
  assign wr_acc = clr_n && !flush && wr_en && (!full || rd_en);
  assign rd_acc = clr_n && !flush && rd_en && !empty;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (flush) begin
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      count_next     = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_next = ptr_inc(wr_ptr_reg);
      if (rd_acc) rd_ptr_next = ptr_inc(rd_ptr_reg);
      case ({wr_acc, rd_acc})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
      if (wr_en && full && !rd_en) overflow_next  = 1'b1;
      if (rd_en && empty)          underflow_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign wr_ptr    = wr_ptr_reg;
  assign rd_ptr    = rd_ptr_reg;
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

endmodule

// File: rtl/reg_fifo.sv
// Register-based show-ahead FIFO used as an elastic buffer between FFT stages.
// Holds the entry registers and the head-word mux; control lives in reg_fifo_ctrl.
module reg_fifo
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_WORD_W,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = 6
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_param_err
    $error("reg_fifo: need DEPTH >= 2 and 1 <= AF_THRESH <= DEPTH");
  end

  logic                  wr_acc;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] entry_q [DEPTH];
  logic [DATA_WIDTH-1:0] head_word;

  reg_fifo_ctrl #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH)
  ) u_ctrl (
    .clk         (clk),
    .clr_n       (clr_n),
    .flush       (flush),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .wr_acc      (wr_acc),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // Entries are never reset; stale contents are hidden by the empty gating below.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [DATA_WIDTH-1:0] data_reg;
    always_ff @(posedge clk) begin
      if (wr_acc && wr_ptr == PTR_W'(gi)) data_reg <= wr_data;
    end
    assign entry_q[gi] = data_reg;
  end

  always_comb begin
    head_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_ptr == PTR_W'(i)) head_word = entry_q[i];
    end
  end

  assign rd_data = empty ? '0 : head_word;

endmodule

// File: tb/tb_reg_fifo.sv
// Scoreboard bench for reg_fifo: directed stimulus pushes expected words,
// per-instance monitors pop and compare on every accepted pop.
module tb_reg_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: DEPTH=4, AF_THRESH=3
  logic        clr_n_a = 1'b0, flush_a = 1'b0, wr_en_a = 1'b0, rd_en_a = 1'b0;
  logic [15:0] wr_data_a = '0, rd_data_a;
  logic        full_a, empty_a, af_a, ov_a, un_a;
  logic [2:0]  count_a;

  // Instance B: DEPTH=5, AF_THRESH=4
  logic        clr_n_b = 1'b0, flush_b = 1'b0, wr_en_b = 1'b0, rd_en_b = 1'b0;
  logic [15:0] wr_data_b = '0, rd_data_b;
  logic        full_b, empty_b, af_b, ov_b, un_b;
  logic [2:0]  count_b;

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  reg_fifo #(.DATA_WIDTH(16), .DEPTH(4), .AF_THRESH(3)) dut_a (
    .clk(clk), .clr_n(clr_n_a), .flush(flush_a), .wr_en(wr_en_a), .wr_data(wr_data_a),
    .rd_en(rd_en_a), .rd_data(rd_data_a), .full(full_a), .empty(empty_a),
    .almost_full(af_a), .count(count_a), .overflow(ov_a), .underflow(un_a)
  );

  reg_fifo #(.DATA_WIDTH(16), .DEPTH(5), .AF_THRESH(4)) dut_b (
    .clk(clk), .clr_n(clr_n_b), .flush(flush_b), .wr_en(wr_en_b), .wr_data(wr_data_b),
    .rd_en(rd_en_b), .rd_data(rd_data_b), .full(full_b), .empty(empty_b),
    .almost_full(af_b), .count(count_b), .overflow(ov_b), .underflow(un_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitors: an accepted pop is visible at the negedge before the popping edge.
  always @(negedge clk) begin
    if (clr_n_a && !flush_a && rd_en_a && !empty_a) begin
      if (exp_a.size() == 0) begin
        total++; bad++;
        $display("FAIL pop_a: got=%h expected=<none>", rd_data_a);
      end else begin
        chk("pop_a", 32'(rd_data_a), 32'(exp_a.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (clr_n_b && !flush_b && rd_en_b && !empty_b) begin
      if (exp_b.size() == 0) begin
        total++; bad++;
        $display("FAIL pop_b: got=%h expected=<none>", rd_data_b);
      end else begin
        chk("pop_b", 32'(rd_data_b), 32'(exp_b.pop_front()));
      end
    end
  end

  task automatic step_a(input logic wr, input logic [15:0] d, input logic rd, input logic fl);
    wr_en_a = wr; wr_data_a = d; rd_en_a = rd; flush_a = fl;
    @(posedge clk); #1;
  endtask

  task automatic step_b(input logic wr, input logic [15:0] d, input logic rd);
    wr_en_b = wr; wr_data_b = d; rd_en_b = rd;
    @(posedge clk); #1;
  endtask

  task automatic status_a(input string tag, input int cnt, input logic e, input logic f,
                          input logic af, input logic ov, input logic un);
    chk({tag, ".count"}, 32'(count_a), 32'(cnt));
    chk({tag, ".empty"}, 32'(empty_a), 32'(e));
    chk({tag, ".full"},  32'(full_a),  32'(f));
    chk({tag, ".af"},    32'(af_a),    32'(af));
    chk({tag, ".ovf"},   32'(ov_a),    32'(ov));
    chk({tag, ".unf"},   32'(un_a),    32'(un));
  endtask

  logic [15:0] a_words [4] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};

  initial begin
    // Reset both instances
    @(posedge clk); @(posedge clk); #1;
    status_a("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.rd_data", 32'(rd_data_a), 32'h0);
    chk("reset_b.empty", 32'(empty_b), 32'h1);
    clr_n_a = 1'b1; clr_n_b = 1'b1;

    // 1. Fill to full
    for (int i = 0; i < 4; i++) begin
      step_a(1'b1, a_words[i], 1'b0, 1'b0);
      exp_a.push_back(a_words[i]);
      chk("fill.count", 32'(count_a), 32'(i + 1));
      chk("fill.af", 32'(af_a), 32'(i + 1 >= 3));
      chk("fill.full", 32'(full_a), 32'(i + 1 == 4));
      chk("fill.rd_data", 32'(rd_data_a), 32'h0000A001);
    end

    // 2. Write while full without pop is dropped
    step_a(1'b1, 16'hBEEF, 1'b0, 1'b0);
    status_a("ovf", 4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step_a(1'b0, 16'h0, 1'b1, 1'b0);
    status_a("drain1", 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // 3. Full with simultaneous write and pop; data wraps into entry 0
    for (int i = 0; i < 4; i++) begin
      step_a(1'b1, a_words[i], 1'b0, 1'b0);
      exp_a.push_back(a_words[i]);
    end
    step_a(1'b1, 16'h0055, 1'b1, 1'b0);
    exp_a.push_back(16'h0055);
    chk("wr_rd_full.count", 32'(count_a), 32'd4);
    chk("wr_rd_full.head", 32'(rd_data_a), 32'h0000A002);
    for (int i = 0; i < 4; i++) step_a(1'b0, 16'h0, 1'b1, 1'b0);
    chk("drain2.empty", 32'(empty_a), 32'h1);
    chk("drain2.rd_data", 32'(rd_data_a), 32'h0);

    // 4. Empty with simultaneous write and pop
    step_a(1'b1, 16'h1234, 1'b1, 1'b0);
    exp_a.push_back(16'h1234);
    chk("wr_rd_empty.unf", 32'(un_a), 32'h1);
    chk("wr_rd_empty.count", 32'(count_a), 32'd1);
    chk("wr_rd_empty.rd_data", 32'(rd_data_a), 32'h00001234);

    // 5. Flush with a write in the same cycle at count=3
    step_a(1'b1, 16'h2222, 1'b0, 1'b0);
    step_a(1'b1, 16'h3333, 1'b0, 1'b0);
    chk("preflush.count", 32'(count_a), 32'd3);
    step_a(1'b1, 16'h7777, 1'b0, 1'b1);
    exp_a.delete();
    status_a("flush", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flush.rd_data", 32'(rd_data_a), 32'h0);

    // 7. Reset mid-burst with count=2 and underflow set
    step_a(1'b0, 16'h0, 1'b1, 1'b0);
    chk("pop_empty.unf", 32'(un_a), 32'h1);
    step_a(1'b1, 16'hC001, 1'b0, 1'b0);
    step_a(1'b1, 16'hC002, 1'b0, 1'b0);
    chk("preclr.count", 32'(count_a), 32'd2);
    clr_n_a = 1'b0;
    step_a(1'b1, 16'hC003, 1'b0, 1'b0);
    exp_a.delete();
    clr_n_a = 1'b1;
    status_a("clr", 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr.rd_data", 32'(rd_data_a), 32'h0);
    step_a(1'b1, 16'hC004, 1'b0, 1'b0);
    exp_a.push_back(16'hC004);
    step_a(1'b0, 16'h0, 1'b1, 1'b0);
    step_a(1'b0, 16'h0, 1'b0, 1'b0);
    chk("post_clr.empty", 32'(empty_a), 32'h1);
    chk("scoreboard_a.left", 32'(exp_a.size()), 32'd0);

    // 6. DEPTH=5: two words in flight, 12 write/pop pairs, then drain
    for (int i = 0; i < 2; i++) begin
      step_b(1'b1, 16'hB000 + 16'(i), 1'b0);
      exp_b.push_back(16'hB000 + 16'(i));
    end
    for (int i = 2; i < 14; i++) begin
      step_b(1'b1, 16'hB000 + 16'(i), 1'b1);
      exp_b.push_back(16'hB000 + 16'(i));
      chk("b_pair.count", 32'(count_b), 32'd2);
    end
    step_b(1'b0, 16'h0, 1'b1);
    step_b(1'b0, 16'h0, 1'b1);
    step_b(1'b0, 16'h0, 1'b0);
    chk("b_drain.empty", 32'(empty_b), 32'h1);
    chk("b_flags", 32'({ov_b, un_b}), 32'h0);
    chk("scoreboard_b.left", 32'(exp_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
